// File: rtl/asg_sweep_sched.sv
// Frequency-sweep scheduler: steps a DDS through a phase-increment table,
// runs one measurement per point and stores results. Option: SWEEP_TIMEOUT_EN.
module asg_sweep_sched #(
   parameter int ADDR_WIDTH   = 8,
   parameter int STEP_WIDTH   = 32,
   parameter int SETTLE_WIDTH = 24,
   parameter int RES_WIDTH    = 32
) (
   input  logic                    dac_clk_i,
   input  logic                    dac_rst_i,
   input  logic                    start_i,
   input  logic                    abort_i,
   input  logic [ADDR_WIDTH:0]     npts_i,
   input  logic [SETTLE_WIDTH-1:0] settle_i,
   output logic [ADDR_WIDTH-1:0]   tbl_addr_o,
   input  logic [STEP_WIDTH-1:0]   tbl_data_i,
   output logic [STEP_WIDTH-1:0]   step_o,
   output logic                    step_vld_o,
   output logic                    meas_start_o,
   input  logic                    meas_done_i,
   input  logic [RES_WIDTH-1:0]    meas_mod_i,
   input  logic [RES_WIDTH-1:0]    meas_phase_i,
   output logic                    res_we_o,
   output logic [ADDR_WIDTH-1:0]   res_addr_o,
   output logic [RES_WIDTH-1:0]    res_mod_o,
   output logic [RES_WIDTH-1:0]    res_phase_o,
   output logic [ADDR_WIDTH-1:0]   point_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SETTLE,
      S_MEAS,
      S_STORE
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH:0]     npts_q;
   logic [SETTLE_WIDTH-1:0] settle_q;
   logic [SETTLE_WIDTH-1:0] cnt;
   logic [ADDR_WIDTH-1:0]   idx;
   logic                    last_pt;

   assign last_pt    = ({1'b0, idx} == (npts_q - 1'b1));
   assign tbl_addr_o = idx;
   assign res_addr_o = idx;
   assign point_o    = idx;
   assign busy_o     = (state != S_IDLE);

`ifdef SWEEP_TIMEOUT_EN
   logic [19:0] wd;
   logic        err_q;
   logic        tmo;

   // wd stays 0 through the entry cycle, so all-ones marks 2^20 cycles
   assign tmo   = (wd == '1) && !meas_start_o;
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         state        <= S_IDLE;
         npts_q       <= '0;
         settle_q     <= '0;
         cnt          <= '0;
         idx          <= '0;
         step_o       <= '0;
         step_vld_o   <= 1'b0;
         meas_start_o <= 1'b0;
         res_we_o     <= 1'b0;
         res_mod_o    <= '0;
         res_phase_o  <= '0;
         done_o       <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
         wd           <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         step_vld_o   <= 1'b0;
         meas_start_o <= 1'b0;
         res_we_o     <= 1'b0;
         done_o       <= 1'b0;
         if (abort_i) begin
            state <= S_IDLE;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start_i) begin
                     npts_q   <= npts_i;
                     settle_q <= settle_i;
                     idx      <= '0;
`ifdef SWEEP_TIMEOUT_EN
                     err_q    <= 1'b0;
`endif
                     if (npts_i == '0)
                        done_o <= 1'b1;
                     else
                        state <= S_FETCH;
                  end
               end
               S_FETCH: state <= S_LOAD;
               S_LOAD: begin
                  step_o     <= tbl_data_i;
                  step_vld_o <= 1'b1;
                  if (settle_q == '0) begin
                     state        <= S_MEAS;
                     meas_start_o <= 1'b1;
`ifdef SWEEP_TIMEOUT_EN
                     wd           <= '0;
`endif
                  end else begin
                     cnt   <= settle_q - 1'b1;
                     state <= S_SETTLE;
                  end
               end
               S_SETTLE: begin
                  if (cnt == '0) begin
                     state        <= S_MEAS;
                     meas_start_o <= 1'b1;
`ifdef SWEEP_TIMEOUT_EN
                     wd           <= '0;
`endif
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               S_MEAS: begin
                  if (meas_done_i && !meas_start_o) begin
                     res_mod_o   <= meas_mod_i;
                     res_phase_o <= meas_phase_i;
                     res_we_o    <= 1'b1;
                     state       <= S_STORE;
                  end
`ifdef SWEEP_TIMEOUT_EN
                  else if (tmo) begin
                     res_mod_o   <= '0;
                     res_phase_o <= '0;
                     res_we_o    <= 1'b1;
                     err_q       <= 1'b1;
                     state       <= S_STORE;
                  end else if (!meas_start_o) begin
                     wd <= wd + 1'b1;
                  end
`endif
               end
               S_STORE: begin
                  if (last_pt) begin
                     state  <= S_IDLE;
                     done_o <= 1'b1;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= S_FETCH;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_asg_sweep_sched.sv
// Directed bench for asg_sweep_sched: table of sweep vectors plus
// hand-built abort, restart, held-done and full-range sequences.
module tb_asg_sweep_sched;

   localparam int AW = 8;
   localparam int SW = 32;
   localparam int TW = 24;
   localparam int RW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [AW:0]   npts_i = '0;
   logic [TW-1:0] settle_i = '0;
   logic [AW-1:0] tbl_addr_o;
   logic [SW-1:0] tbl_data_i = '0;
   logic [SW-1:0] step_o;
   logic          step_vld_o;
   logic          meas_start_o;
   logic          meas_done_i = 1'b0;
   logic [RW-1:0] meas_mod_i = '0;
   logic [RW-1:0] meas_phase_i = '0;
   logic          res_we_o;
   logic [AW-1:0] res_addr_o;
   logic [RW-1:0] res_mod_o;
   logic [RW-1:0] res_phase_o;
   logic [AW-1:0] point_o;
   logic          busy_o;
   logic          done_o;
   logic          err_o;

   asg_sweep_sched #(
      .ADDR_WIDTH(AW), .STEP_WIDTH(SW),
      .SETTLE_WIDTH(TW), .RES_WIDTH(RW)
   ) dut (
      .dac_clk_i   (clk),
      .dac_rst_i   (rst),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .npts_i      (npts_i),
      .settle_i    (settle_i),
      .tbl_addr_o  (tbl_addr_o),
      .tbl_data_i  (tbl_data_i),
      .step_o      (step_o),
      .step_vld_o  (step_vld_o),
      .meas_start_o(meas_start_o),
      .meas_done_i (meas_done_i),
      .meas_mod_i  (meas_mod_i),
      .meas_phase_i(meas_phase_i),
      .res_we_o    (res_we_o),
      .res_addr_o  (res_addr_o),
      .res_mod_o   (res_mod_o),
      .res_phase_o (res_phase_o),
      .point_o     (point_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;

   logic [SW-1:0] tbl [0:255];

   typedef struct {
      int            addr;
      logic [RW-1:0] m;
      logic [RW-1:0] p;
      int            c;
   } wr_t;

   wr_t  wrs[$];
   int   done_cnt;
   int   done_c;
   int   ms_first;
   int   sv_first;
   logic busy_seen;

   int eng_mode  = 0;
   int eng_delay = 10;
   int eng_cnt   = 0;
   int eng_pt    = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      wrs.delete();
      done_cnt  = 0;
      done_c    = -1;
      ms_first  = -1;
      sv_first  = -1;
      busy_seen = 1'b0;
   endtask

   task automatic start_sweep(input int n, input int s);
      @(negedge clk);
      clear_logs();
      npts_i    = (AW+1)'(n);
      settle_i  = TW'(s);
      start_i   = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string name);
      int k = 0;
      while (done_cnt == 0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL %s_timeout: no done_o after %0d cycles, required done_o",
                  name, bound);
      end
      repeat (3) @(negedge clk);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // step table with one cycle of read latency
   initial forever begin
      @(negedge clk);
      tbl_data_i = tbl[tbl_addr_o];
   end

   // measurement engine model
   initial forever begin
      @(negedge clk);
      if (eng_mode == 2) begin
         meas_done_i  = 1'b1;
         meas_mod_i   = 32'h55;
         meas_phase_i = 32'hAA;
      end else begin
         meas_done_i  = 1'b0;
         meas_mod_i   = 32'hDEADBEEF;
         meas_phase_i = 32'hDEADBEEF;
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               meas_done_i  = 1'b1;
               meas_mod_i   = RW'(eng_pt + 1);
               meas_phase_i = RW'(32'h1000 + eng_pt);
            end
         end
         if (meas_start_o &&
             (eng_mode == 0 || (eng_mode == 3 && point_o != '0))) begin
            eng_cnt = eng_delay;
            eng_pt  = int'(point_o);
         end
      end
   end

   // event monitor
   initial forever begin
      wr_t w;
      @(negedge clk);
      if (res_we_o) begin
         w.addr = int'(res_addr_o);
         w.m    = res_mod_o;
         w.p    = res_phase_o;
         w.c    = cyc - start_cyc;
         wrs.push_back(w);
      end
      if (done_o) begin
         done_cnt++;
         done_c = cyc - start_cyc;
      end
      if (meas_start_o && ms_first < 0) ms_first = cyc - start_cyc;
      if (step_vld_o && sv_first < 0) sv_first = cyc - start_cyc;
      if (busy_o) busy_seen = 1'b1;
   end

   typedef struct {
      int n;
      int s;
      int d;
      int exp_done;
      int exp_ms;
      int exp_sv;
   } vec_t;

   vec_t vecs[6];

   initial begin
      for (int i = 0; i < 256; i++) tbl[i] = SW'((i + 1) * 32'h100);

      // done cycle = 1 + n*(4+s+d); first meas_start = 3+s
      vecs[0] = '{3, 5, 10, 58, 8, 3};
      vecs[1] = '{1, 0, 3, 8, 3, 3};
      vecs[2] = '{0, 0, 3, 1, -1, -1};
      vecs[3] = '{4, 2, 1, 29, 5, 3};
      vecs[4] = '{5, 1, 2, 36, 4, 3};
      vecs[5] = '{2, 7, 4, 31, 10, 3};

      clear_logs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {tbl_addr_o, step_o, step_vld_o, meas_start_o, res_we_o,
           res_addr_o, point_o, busy_o, done_o, err_o}, '0);
      chk("reset_res", {res_mod_o, res_phase_o}, '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_after_reset", {busy_o, done_o}, '0);

      for (int v = 0; v < 6; v++) begin
         int p;
         eng_mode  = 0;
         eng_delay = vecs[v].d;
         p = 4 + vecs[v].s + vecs[v].d;
         start_sweep(vecs[v].n, vecs[v].s);
         wait_done(2000, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_done_cnt", v), done_cnt, 1);
         chk($sformatf("vec%0d_done_cyc", v), done_c, vecs[v].exp_done);
         chk($sformatf("vec%0d_nwrites", v), wrs.size(), vecs[v].n);
         chk($sformatf("vec%0d_ms_cyc", v), ms_first, vecs[v].exp_ms);
         chk($sformatf("vec%0d_sv_cyc", v), sv_first, vecs[v].exp_sv);
         chk($sformatf("vec%0d_busy_seen", v), busy_seen, vecs[v].n != 0);
         chk($sformatf("vec%0d_idle", v), {busy_o, err_o}, '0);
         for (int i = 0; i < wrs.size() && i < vecs[v].n; i++) begin
            chk($sformatf("vec%0d_w%0d_addr", v, i), wrs[i].addr, i);
            chk($sformatf("vec%0d_w%0d_mod", v, i), wrs[i].m, i + 1);
            chk($sformatf("vec%0d_w%0d_ph", v, i), wrs[i].p, 32'h1000 + i);
            chk($sformatf("vec%0d_w%0d_cyc", v, i), wrs[i].c, (i + 1) * p);
         end
         if (vecs[v].n > 0)
            chk($sformatf("vec%0d_step", v), step_o, tbl[vecs[v].n - 1]);
      end

      // abort during SETTLE of point 1 (settle cycles 22..26)
      eng_delay = 10;
      start_sweep(4, 5);
      repeat (22) @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      chk("abort_idle_next", busy_o, 1'b0);
      repeat (40) @(negedge clk);
      chk("abort_nwrites", wrs.size(), 1);
      if (wrs.size() > 0) chk("abort_w0_addr", wrs[0].addr, 0);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_step_hold", step_o, tbl[1]);
      chk("abort_still_idle", busy_o, 1'b0);

      // start pulsed mid-sweep with a different npts
      start_sweep(3, 5);
      repeat (9) @(negedge clk);
      npts_i  = 9'd7;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_done(2000, "midstart");
      chk("midstart_nwrites", wrs.size(), 3);
      chk("midstart_done_cyc", done_c, 58);
      if (wrs.size() == 3) chk("midstart_last_addr", wrs[2].addr, 2);

      // abort and start together in IDLE
      @(negedge clk);
      clear_logs();
      npts_i    = 9'd3;
      settle_i  = '0;
      start_i   = 1'b1;
      abort_i   = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start_i = 1'b0;
      abort_i = 1'b0;
      chk("abortstart_busy", busy_o, 1'b0);
      repeat (20) @(negedge clk);
      chk("abortstart_seen", busy_seen, 1'b0);
      chk("abortstart_writes", wrs.size(), 0);
      chk("abortstart_done", done_cnt, 0);

      // done held high: entry cycle must ignore it
      eng_mode = 2;
      start_sweep(1, 0);
      wait_done(50, "heldone");
      eng_mode = 0;
      chk("heldone_nwrites", wrs.size(), 1);
      if (wrs.size() > 0) begin
         chk("heldone_w_cyc", wrs[0].c, 5);
         chk("heldone_w_mod", wrs[0].m, 32'h55);
      end
      chk("heldone_done_cyc", done_c, 6);

      // full 2^ADDR_WIDTH sweep, no wrap
      eng_delay = 1;
      start_sweep(256, 0);
      wait_done(1500, "wrap");
      chk("wrap_nwrites", wrs.size(), 256);
      chk("wrap_done_cyc", done_c, 1281);
      chk("wrap_done_cnt", done_cnt, 1);
      if (wrs.size() == 256) begin
         chk("wrap_first_addr", wrs[0].addr, 0);
         chk("wrap_last_addr", wrs[255].addr, 255);
         chk("wrap_last_mod", wrs[255].m, 256);
      end
      chk("wrap_step", step_o, tbl[255]);

`ifdef SWEEP_TIMEOUT_EN
      eng_mode  = 3;
      eng_delay = 4;
      start_sweep(2, 0);
      wait_done((1 << 20) + 200, "tmo");
      chk("tmo_nwrites", wrs.size(), 2);
      if (wrs.size() == 2) begin
         chk("tmo_w0_cyc", wrs[0].c, 3 + (1 << 20) + 1);
         chk("tmo_w0_data", {wrs[0].m, wrs[0].p}, '0);
         chk("tmo_w1_mod", wrs[1].m, 2);
      end
      chk("tmo_err_set", err_o, 1'b1);
      repeat (5) @(negedge clk);
      chk("tmo_err_sticky", err_o, 1'b1);
      eng_mode = 0;
      start_sweep(1, 0);
      wait_done(100, "tmo_clear");
      chk("tmo_err_cleared", err_o, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
